// File: rtl/video_frame_writer.sv
// video_frame_writer: buffers scaler pixels in a FIFO and writes whole frames as fixed bursts
// into two ping-pong frame buffers, reporting the last complete one to the read side.
module video_frame_writer #(
   parameter int H_ACT = 640,
   parameter int V_ACT = 480,
   parameter int BURST_LEN = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_W = 28,
   parameter logic [ADDR_W-1:0] FRAME_BASE0 = 28'h000_0000,
   parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h004_B000
) (
   input  logic                          pixclk_in,
   input  logic                          rst_n,
   input  logic                          vs_in,
   input  logic                          de_in,
   input  logic [31:0]                   wr_data,
   output logic                          wr_req,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [7:0]                    wr_len,
   input  logic                          wr_ack,
   output logic [31:0]                   wr_dout,
   output logic                          wr_dout_valid,
   input  logic                          wr_dout_ready,
   output logic                          rd_frame_sel,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int TOTAL = H_ACT * V_ACT;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(TOTAL + 1);
   localparam int BW = $clog2(BURST_LEN);
   localparam logic [CW-1:0] TOT = CW'(TOTAL);
   localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);
   localparam logic [LW-1:0] BL_L = LW'(BURST_LEN);
   localparam logic [LW-1:0] FULL_L = LW'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
   state_t state_q, state_d;
   logic vs_q, vs_d, pending_q, pending_d, armed_q, armed_d, wr_sel_q, wr_sel_d;
   logic done_q, done_d, rd_sel_q, rd_sel_d, fd_q, fd_d, ovf_q, ovf_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0] pix_q, pix_d, wcnt_q, wcnt_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [LW-1:0] wp_q, wp_d, rp_q, rp_d, level;
   logic [31:0] mem [FIFO_DEPTH];
   logic start, restart, full, try_push, push, beat, last, fin;
   assign start = vs_in & ~vs_q;
   // a start seen mid-burst is deferred until the burst has fully drained
   assign restart = (state_q == IDLE) & (start | pending_q);
   assign level = wp_q - rp_q;
   assign full = level == FULL_L;
   assign try_push = armed_q & de_in & ~vs_in & ~pending_q & (pix_q < TOT);
   assign push = try_push & ~full;
   assign beat = (state_q == DATA) & wr_dout_ready;
   assign last = beat & (beat_q == BW'(BURST_LEN - 1));
   assign fin = last & (wcnt_q + BL_C == TOT);
   always_ff @(posedge pixclk_in or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = (~restart & ~done_q & (level >= BL_L)) ? REQ : IDLE;
         REQ: state_d = wr_ack ? DATA : REQ;
         default: state_d = last ? IDLE : DATA;
      endcase
   end
   always_comb begin
      wr_req = state_q == REQ;
      wr_dout_valid = state_q == DATA;
      wr_addr = addr_q;
      wr_len = 8'(BURST_LEN);
      wr_dout = mem[rp_q[PW-1:0]];
      rd_frame_sel = rd_sel_q;
      frame_done = fd_q;
      overflow = ovf_q;
      fifo_level = level;
   end
   always_comb begin
      vs_d = vs_in;
      pending_d = restart ? 1'b0 : pending_q | (start & (state_q != IDLE));
      wr_sel_d = (restart & done_q) ? ~wr_sel_q : wr_sel_q;
      armed_d = armed_q | restart;
      done_d = restart ? 1'b0 : done_q | fin;
      rd_sel_d = fin ? wr_sel_q : rd_sel_q;
      addr_d = restart ? (wr_sel_d ? FRAME_BASE1 : FRAME_BASE0) : last ? addr_q + ADDR_W'(BURST_LEN) : addr_q;
      pix_d = restart ? '0 : pix_q + CW'(push);
      wcnt_d = restart ? '0 : last ? wcnt_q + BL_C : wcnt_q;
      beat_d = (state_q == REQ) ? '0 : beat ? beat_q + 1'b1 : beat_q;
      fd_d = fin;
      ovf_d = ovf_q | (try_push & full);
      wp_d = restart ? '0 : wp_q + LW'(push);
      rp_d = restart ? '0 : rp_q + LW'(beat);
   end
   always_ff @(posedge pixclk_in or negedge rst_n)
      if (!rst_n) begin
         vs_q <= 1'b0;
         pending_q <= 1'b0;
         armed_q <= 1'b0;
         wr_sel_q <= 1'b0;
         done_q <= 1'b0;
         rd_sel_q <= 1'b1;
         fd_q <= 1'b0;
         ovf_q <= 1'b0;
         addr_q <= FRAME_BASE0;
         pix_q <= '0;
         wcnt_q <= '0;
         beat_q <= '0;
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         vs_q <= vs_d;
         pending_q <= pending_d;
         armed_q <= armed_d;
         wr_sel_q <= wr_sel_d;
         done_q <= done_d;
         rd_sel_q <= rd_sel_d;
         fd_q <= fd_d;
         ovf_q <= ovf_d;
         addr_q <= addr_d;
         pix_q <= pix_d;
         wcnt_q <= wcnt_d;
         beat_q <= beat_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   always_ff @(posedge pixclk_in)
      if (push) mem[wp_q[PW-1:0]] <= wr_data;
endmodule

// File: tb/tb_video_frame_writer.sv
// tb_video_frame_writer: random-timing stimulus against a queue-based frame writer model,
// checked every cycle, plus literal expectations for addresses, data order and reset values.
module tb_video_frame_writer;
   localparam int BL = 4, DEPTH = 16, TOT = 32, BASE1 = 32;
   logic clk = 0, rst_n = 0, vs_in = 0, de_in = 0, wr_ack, wr_dout_ready;
   logic [31:0] wr_data = 0, wr_dout;
   logic wr_req, wr_dout_valid, rd_frame_sel, frame_done, overflow;
   logic [27:0] wr_addr;
   logic [7:0] wr_len;
   logic [4:0] fifo_level;
   int vectors = 0, errors = 0;
   int ack_dly = 2, rdy_mode = 0;
   bit ack_rand = 0;
   int got_addr[$];
   logic [31:0] got_data[$];
   int fd_cnt = 0;
   bit prev_req = 0;
   logic [31:0] m_q[$];
   int m_pix, m_wcnt, m_beats, m_ph, m_addr;
   bit m_armed, m_pend, m_sel, m_done, m_rdsel, m_fd, m_ovf, m_vsp;

   video_frame_writer #(.H_ACT(8), .V_ACT(4), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
                        .FRAME_BASE0(28'd0), .FRAME_BASE1(28'd32)) dut (
      .pixclk_in(clk), .rst_n(rst_n), .vs_in(vs_in), .de_in(de_in), .wr_data(wr_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
      .wr_dout(wr_dout), .wr_dout_valid(wr_dout_valid), .wr_dout_ready(wr_dout_ready),
      .rd_frame_sel(rd_frame_sel), .frame_done(frame_done), .overflow(overflow),
      .fifo_level(fifo_level));

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_q.delete();
      m_pix = 0; m_wcnt = 0; m_beats = 0; m_ph = 0; m_addr = 0;
      m_armed = 0; m_pend = 0; m_sel = 0; m_done = 0; m_rdsel = 1; m_fd = 0; m_ovf = 0; m_vsp = 0;
   endfunction

   // what the writer must do at the coming clock edge, given the current inputs
   function automatic void m_step();
      bit start = vs_in && !m_vsp;
      bit idle = m_ph == 0;
      bit restart = idle && (start || m_pend);
      bit try_push = m_armed && de_in && !vs_in && !m_pend && m_pix < TOT;
      int size0 = m_q.size();
      bit go = idle && !restart && !m_done && size0 >= BL;
      m_fd = 0;
      m_vsp = vs_in;
      if (start && !idle) m_pend = 1;
      if (restart) begin
         if (m_done) m_sel = !m_sel;
         m_q.delete();
         m_pix = 0; m_wcnt = 0; m_done = 0; m_armed = 1; m_pend = 0;
         m_addr = m_sel ? BASE1 : 0;
      end
      if (try_push) begin
         if (size0 < DEPTH) begin m_q.push_back(wr_data); m_pix++; end
         else m_ovf = 1;
      end
      if (m_ph == 0 && go) m_ph = 1;
      else if (m_ph == 1 && wr_ack) begin m_ph = 2; m_beats = 0; end
      else if (m_ph == 2 && wr_dout_ready) begin
         void'(m_q.pop_front());
         m_beats++;
         if (m_beats == BL) begin
            m_ph = 0; m_addr += BL; m_wcnt += BL;
            if (m_wcnt == TOT) begin m_fd = 1; m_rdsel = m_sel; m_done = 1; end
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) m_reset();
      chk("wr_req", wr_req, m_ph == 1);
      chk("wr_dout_valid", wr_dout_valid, m_ph == 2);
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_len", wr_len, BL);
      chk("frame_done", frame_done, m_fd);
      chk("rd_frame_sel", rd_frame_sel, m_rdsel);
      chk("overflow", overflow, m_ovf);
      chk("fifo_level", fifo_level, m_q.size());
      if (m_ph == 2) chk("wr_dout", wr_dout, m_q[0]);
      if (wr_req && !prev_req) got_addr.push_back(int'(wr_addr));
      if (wr_dout_valid && wr_dout_ready) got_data.push_back(wr_dout);
      if (frame_done) fd_cnt++;
      prev_req = wr_req;
      if (rst_n) m_step();
   end

   initial begin
      int wait_c = -1;
      wr_ack = 0;
      wr_dout_ready = 0;
      forever begin
         @(posedge clk); #1;
         wr_ack = 0;
         wr_dout_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
         if (wr_req) begin
            if (wait_c < 0) wait_c = ack_rand ? int'($urandom_range(0, 5)) : ack_dly;
            if (wait_c == 0) begin wr_ack = 1; wait_c = -1; end
            else wait_c--;
         end else wait_c = -1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic vs_pulse();
      de_in = 0; vs_in = 1; tick(); tick();
      vs_in = 0; tick();
   endtask

   task automatic send(int n, int base, int gmin, int gmax, bit rnd);
      for (int i = 0; i < n; i++) begin
         de_in = 1;
         wr_data = rnd ? $urandom : 32'(base + i);
         tick();
         de_in = 0;
         for (int g = int'($urandom_range(gmin, gmax)); g > 0; g--) tick();
      end
      de_in = 0;
   endtask

   task automatic drain();
      int i = 0;
      while (i < 400 && !(m_ph == 0 && m_q.size() < BL)) begin tick(); i++; end
      chk("drain_timeout", i < 400, 1);
      tick(); tick();
   endtask

   task automatic wait_valid();
      int i = 0;
      while (i < 50 && !wr_dout_valid) begin tick(); i++; end
      chk("wait_valid_timeout", wr_dout_valid, 1);
   endtask

   task automatic clr();
      got_addr.delete();
      got_data.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst_n = 1;
      tick();
      send(40, 500, 0, 0, 0);
      repeat (5) tick();
      chk("unarmed_no_req", got_addr.size(), 0);
      chk("unarmed_level", fifo_level, 0);
      clr();
      vs_pulse();
      send(TOT, 0, 2, 2, 0);
      drain();
      chk("f1_bursts", got_addr.size(), 8);
      for (int i = 0; i < 8; i++) chk("f1_addr", got_addr[i], 4 * i);
      for (int i = 0; i < TOT; i++) chk("f1_data", got_data[i], i);
      chk("f1_done_cnt", fd_cnt, 1);
      chk("f1_rd_sel", rd_frame_sel, 0);
      clr();
      vs_pulse();
      send(TOT, 100, 2, 2, 0);
      drain();
      chk("f2_first_addr", got_addr[0], 32);
      chk("f2_last_addr", got_addr[7], 60);
      chk("f2_rd_sel", rd_frame_sel, 1);
      chk("f2_done_cnt", fd_cnt, 2);
      clr();
      ack_rand = 1; rdy_mode = 2;
      vs_pulse();
      send(TOT, 0, 5, 7, 1);
      drain();
      chk("f3_first_addr", got_addr[0], 0);
      chk("f3_beats", got_data.size(), TOT);
      chk("f3_rd_sel", rd_frame_sel, 0);
      chk("f3_done_cnt", fd_cnt, 3);
      chk("f3_no_ovf", overflow, 0);
      ack_rand = 0; ack_dly = 0; rdy_mode = 1;
      vs_pulse();
      send(20, 200, 0, 0, 0);
      chk("ovf_level", fifo_level, 16);
      chk("ovf_set", overflow, 1);
      rdy_mode = 0;
      drain();
      send(16, 300, 3, 3, 0);
      drain();
      chk("f4_rd_sel", rd_frame_sel, 1);
      chk("f4_done_cnt", fd_cnt, 4);
      vs_pulse();
      chk("ovf_sticky", overflow, 1);
      clr();
      send(10, 400, 3, 3, 0);
      drain();
      chk("short_bursts", got_addr.size(), 2);
      chk("short_addr0", got_addr[0], 0);
      chk("short_addr1", got_addr[1], 4);
      chk("short_left", fifo_level, 2);
      vs_pulse();
      chk("short_flushed", fifo_level, 0);
      chk("short_no_done", fd_cnt, 4);
      clr();
      send(4, 450, 1, 1, 0);
      drain();
      chk("short_restart_addr", got_addr[0], 0);
      clr();
      send(4, 600, 0, 0, 0);
      wait_valid();
      tick();
      vs_in = 1; tick(); tick();
      vs_in = 0; tick();
      drain();
      send(4, 700, 0, 0, 0);
      drain();
      chk("vsmid_bursts", got_addr.size(), 2);
      chk("vsmid_addr0", got_addr[0], 4);
      chk("vsmid_addr1", got_addr[1], 0);
      chk("vsmid_beats", got_data.size(), 8);
      rdy_mode = 1;
      send(4, 800, 0, 0, 0);
      wait_valid();
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      chk("rst_wr_req", wr_req, 0);
      chk("rst_valid", wr_dout_valid, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_rd_sel", rd_frame_sel, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_done", frame_done, 0);
      tick(); tick();
      rst_n = 1;
      rdy_mode = 0;
      clr();
      tick();
      send(40, 900, 0, 0, 0);
      repeat (5) tick();
      chk("rst_unarmed_no_req", got_addr.size(), 0);
      chk("rst_unarmed_level", fifo_level, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/video_frame_writer.md
Name: video_frame_writer

Overview:
- Sits directly downstream of the 640x480 scaler, in the pixel clock domain.
- Captures the scaler's sparse valid pixels (de_in qualified, 32-bit {8'h0,R,G,B}) into a FIFO.
- Issues fixed-length burst write requests to the DDR write arbiter, alternating between two frame buffers (ping-pong).
- Reports which buffer holds the last complete frame so the read side can display it.

Parameters:
- H_ACT, 640, active pixels per output line.
- V_ACT, 480, active lines per output frame.
- BURST_LEN, 16, words per write burst. H_ACT*V_ACT must be a multiple of BURST_LEN; no partial bursts exist.
- FIFO_DEPTH, 64, pixel FIFO depth. Power of 2, >= 2*BURST_LEN.
- ADDR_W, 28, word address width.
- FRAME_BASE0, 28'h000_0000, word base address of buffer 0.
- FRAME_BASE1, 28'h004_B000, word base address of buffer 1 (= 640*480).

Ports:
- pixclk_in  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- vs_in  in  1  frame sync from scaler, active high.
- de_in  in  1  pixel valid from scaler.
- wr_data  in  32  pixel {8'h0,R,G,B}.
- wr_req  out  1  burst request; held until wr_ack.
- wr_addr  out  ADDR_W  burst start word address; stable while wr_req=1.
- wr_len  out  8  burst length, constant BURST_LEN.
- wr_ack  in  1  one-cycle request accept from arbiter.
- wr_dout  out  32  burst data, FIFO head (first-word fall-through).
- wr_dout_valid  out  1  burst beat valid.
- wr_dout_ready  in  1  arbiter accepts beat.
- rd_frame_sel  out  1  buffer index of last completed frame.
- frame_done  out  1  one-cycle pulse when a frame's last burst completes.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - wr_req=0, wr_addr=FRAME_BASE0, wr_dout_valid=0, frame_done=0, overflow=0, fifo_level=0.
  - rd_frame_sel=1, meaning nothing valid yet; internal write buffer wr_sel=0.
  - armed=0; state IDLE.
- Frame start:
  - vs_d registered; start event = vs_in & ~vs_d.
  - Pixels arriving before the first start event after reset are ignored (armed=0).
  - de_in while vs_in=1 is ignored.
- Restart action, applied on a start event in IDLE; if the event occurs in REQ or DATA, a pending flag is set and the action is applied the cycle the FSM returns to IDLE:
  - If the previous frame completed (done_flag=1), toggle wr_sel.
  - Flush the FIFO (leftover < BURST_LEN words discarded).
  - Clear the pixel count, written-word count and done_flag.
  - Set the address to the base of wr_sel; set armed=1.
- Pixel intake:
  - Push when armed & de_in & ~vs_in & ~pending & (pixel count < H_ACT*V_ACT) & FIFO not full.
  - If the FIFO is full, the pixel is dropped and overflow is set; it stays set until reset.
  - Pixels beyond H_ACT*V_ACT in a frame are silently dropped.
  - Pixels arriving while pending=1 are dropped.
- FSM:
  - IDLE -> REQ when fifo_level >= BURST_LEN and no restart is pending/applied this cycle.
  - REQ: wr_req=1, wr_addr held. On wr_ack -> DATA with wr_req=0 the next cycle.
  - DATA: wr_dout_valid=1 while beats remain; a beat completes on valid & ready and pops the FIFO.
  - After BURST_LEN beats: wr_addr += BURST_LEN, written count += BURST_LEN, -> IDLE.
- Completion: when the written count reaches H_ACT*V_ACT:
  - frame_done pulses for 1 cycle (the cycle after the final beat).
  - rd_frame_sel <= wr_sel; done_flag=1.
  - No further bursts until the next restart.
- A short frame (start event before completion) produces no frame_done and reuses the same buffer.
- Simultaneous push and pop in one cycle: level unchanged; FIFO full/empty computed with the extra pointer bit.
- Latency: the earliest wr_req is 1 cycle after fifo_level reaches BURST_LEN.
- The FSM never drops or repeats a beat under any wr_dout_ready pattern.

Test Plan (bench parameters H_ACT=8, V_ACT=4, BURST_LEN=4, FIFO_DEPTH=16, FRAME_BASE1=32):
- Reset mid-burst -> all outputs return to reset values immediately; rd_frame_sel=1; 40 de pulses without vs -> no wr_req.
- vs pulse, then 32 pixels 0..31, ack after 2 cycles, ready=1 ->
  - 8 bursts at wr_addr 0,4,...,28 with data 0..31 in order;
  - frame_done once; rd_frame_sel=0.
- Second full frame -> bursts at addresses 32..60; rd_frame_sel=1.
- Third frame -> writes return to buffer 0 (addresses 0..28).
- wr_dout_ready toggled randomly, wr_ack delayed 0-5 cycles -> identical data order; wr_addr stable while wr_req=1.
- wr_dout_ready held 0 while 20 pixels arrive -> 16 stored, overflow=1 and stays 1 after a later vs.
- Frame with 10 pixels then vs -> bursts at 0 and 4 only; 2 words flushed; no frame_done; next frame starts again at address 0.
- vs rising during DATA beat 2 -> burst completes all 4 beats; restart applied on return to IDLE; next burst address = buffer base.
